hplvds_rx_lane_ctrl: RTL
========================

Name:
hplvds_rx_lane_ctrl

Overview:
Digital control and retiming front-end for NUM_LANES HPLVDS receiver pad cells.
- Per lane, sequences power-up of termination, receiver and EI detector with programmable settle times.
- Synchronises and polarity-corrects received data.
- Debounces the electrical-idle (EI) indication into a clean idle state with an entry event pulse.
- Sits between the HPLVDS RX pad ring and the link-layer deserialiser. Pad-cell RX_POL_I is tied 0; polarity is applied here.

Parameters:
NUM_LANES, 4, number of independent receiver lanes (>=1)
TERM_SETTLE, 16, cycles in TERM state before receiver enable (>=1)
RX_SETTLE, 32, cycles in RXSET state before data is valid (>=1)
EI_FILT, 8, consecutive synchronised EI samples needed to enter or leave IDLE (>=1)
SYNC_STAGES, 2, flop stages on DI_I and EI_DETECT_I (>=2)

Ports:
CLK_I  in  1  block clock
RSTN_I  in  1  reset
LANE_EN_I  in  NUM_LANES  per-lane power-up request, level
RX_POL_I  in  NUM_LANES  per-lane data inversion, quasi-static
DI_I  in  NUM_LANES  raw data from pad DI_O, asynchronous
EI_DETECT_I  in  NUM_LANES  raw EI flag from pad EI_DETECT_O, asynchronous
RTERM_EN_O  out  NUM_LANES  to pad RTERM_EN_I
RX_EN_O  out  NUM_LANES  to pad RX_EN_I
EI_DETECT_EN_O  out  NUM_LANES  to pad EI_DETECT_EN_I
DATA_O  out  NUM_LANES  retimed, polarity-corrected data
LANE_READY_O  out  NUM_LANES  lane in ACTIVE
LANE_IDLE_O  out  NUM_LANES  lane in IDLE
EI_EVENT_O  out  NUM_LANES  one-cycle pulse on ACTIVE->IDLE transition

Behaviour:
- Clock and reset: single clock CLK_I. Reset RSTN_I is asynchronous, active-low.
- Reset values: all outputs 0, all lanes in OFF, all counters and synchroniser flops 0.
- Lanes are fully independent. Each lane has its own FSM, settle counter and EI filter counter.
- Counter width is $clog2 of the maximum of TERM_SETTLE, RX_SETTLE and EI_FILT, plus 1.
- Synchronisers: DI_I and EI_DETECT_I each pass through SYNC_STAGES flops, giving di_s and ei_s.

FSM states: OFF, TERM, RXSET, ACTIVE, IDLE.
- OFF -> TERM when LANE_EN_I=1; cnt cleared.
- TERM -> RXSET after exactly TERM_SETTLE cycles in TERM (cnt==TERM_SETTLE-1); cnt cleared.
- RXSET -> ACTIVE after exactly RX_SETTLE cycles; EI filter counter cleared.
- ACTIVE -> IDLE when ei_s has been 1 for EI_FILT consecutive cycles. A 0 sample clears the filter counter. The filter counter is cleared on entry to IDLE.
- IDLE -> ACTIVE when ei_s has been 0 for EI_FILT consecutive cycles. A 1 sample clears the filter counter.
- Any state -> OFF on the first edge with LANE_EN_I=0. This overrides all other transitions in the same cycle and clears all lane counters. Mid-sequence deassert aborts cleanly; re-assert restarts from TERM with full settle times.
- EI is ignored in OFF, TERM and RXSET.

Outputs are registered and decoded from next-state, so they change on the same edge as the state:
- RTERM_EN_O = 1 in TERM, RXSET, ACTIVE, IDLE.
- RX_EN_O and EI_DETECT_EN_O = 1 in RXSET, ACTIVE, IDLE.
- LANE_READY_O = 1 only in ACTIVE.
- LANE_IDLE_O = 1 only in IDLE.
- EI_EVENT_O = 1 for exactly one cycle on the edge entering IDLE from ACTIVE. It does not pulse on OFF entry.
- DATA_O = di_s XOR RX_POL_I, registered, when next state is ACTIVE; otherwise 0.
- DI_I -> DATA_O latency is SYNC_STAGES+1 cycles.
- RX_POL_I change takes effect on the next DATA_O update; no glitch filtering.

Simultaneous events:
- LANE_EN_I falling on the same edge as an EI filter completion: OFF wins, and no EI_EVENT_O pulse is produced.

Test Plan:
1. Defaults. Reset, then assert LANE_EN_I[0] at edge 0 -> RTERM_EN_O[0]=1 from edge 0; RX_EN_O[0] and EI_DETECT_EN_O[0]=1 from edge 16; LANE_READY_O[0]=1 from edge 48. Other lanes remain 0.
2. Lane 1 ACTIVE, RX_POL_I[1]=1, DI_I[1] toggling 1,0,1,1 -> DATA_O[1] shows 0,1,0,0 delayed 3 cycles.
3. Lane 2 ACTIVE. EI_DETECT_I[2] high for 7 cycles then low -> no IDLE. High for 8 cycles -> LANE_IDLE_O[2] rises 10 cycles after EI rise, EI_EVENT_O[2] pulses exactly once, DATA_O[2]=0. EI low 8 cycles -> LANE_READY_O[2] returns.
4. Drop LANE_EN_I[3] at edge 20 of the sequence (in RXSET) -> all lane-3 outputs 0 next edge. Re-assert -> full 48-cycle sequence again.
5. Assert RSTN_I low asynchronously mid-ACTIVE on all lanes -> all outputs 0 immediately without a clock edge; after release, lanes follow LANE_EN_I from OFF.
6. Lane 0 in ACTIVE with EI filter completing on the same edge LANE_EN_I[0] falls -> lane enters OFF, EI_EVENT_O[0] stays 0.

Source files
------------

// File: rtl/hplvds_rx_lane_ctrl.sv
// HPLVDS receiver lane controller: per-lane power-up sequencing of the pad
// termination, receiver and EI detector, data retiming with polarity
// correction, and debounced electrical-idle tracking.
//
// Lane FSM
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_OFF    | pad fully powered down, waiting for LANE_EN_I
//   ST_TERM   | termination on, waiting TERM_SETTLE cycles
//   ST_RXSET  | receiver and EI detector on, waiting RX_SETTLE cycles
//   ST_ACTIVE | lane ready, data forwarded, watching for EI entry
//   ST_IDLE   | electrical idle, data forced 0, watching for EI exit
module hplvds_rx_lane_ctrl #(
    parameter int NUM_LANES   = 4,
    parameter int TERM_SETTLE = 16,
    parameter int RX_SETTLE   = 32,
    parameter int EI_FILT     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK_I,
    input  logic                 RSTN_I,
    input  logic [NUM_LANES-1:0] LANE_EN_I,
    input  logic [NUM_LANES-1:0] RX_POL_I,
    input  logic [NUM_LANES-1:0] DI_I,
    input  logic [NUM_LANES-1:0] EI_DETECT_I,
    output logic [NUM_LANES-1:0] RTERM_EN_O,
    output logic [NUM_LANES-1:0] RX_EN_O,
    output logic [NUM_LANES-1:0] EI_DETECT_EN_O,
    output logic [NUM_LANES-1:0] DATA_O,
    output logic [NUM_LANES-1:0] LANE_READY_O,
    output logic [NUM_LANES-1:0] LANE_IDLE_O,
    output logic [NUM_LANES-1:0] EI_EVENT_O
);

    localparam int MAX_TR = (TERM_SETTLE > RX_SETTLE) ? TERM_SETTLE : RX_SETTLE;
    localparam int MAX_ALL = (MAX_TR > EI_FILT) ? MAX_TR : EI_FILT;
    localparam int CW = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] TERM_LAST = CW'(TERM_SETTLE - 1);
    localparam logic [CW-1:0] RX_LAST   = CW'(RX_SETTLE - 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(EI_FILT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_TERM,
        ST_RXSET,
        ST_ACTIVE,
        ST_IDLE
    } state_e;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [SYNC_STAGES-1:0] di_sync_q;
        logic [SYNC_STAGES-1:0] ei_sync_q;
        logic                   di_s;
        logic                   ei_s;
        state_e                 state_q, state_d;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic [CW-1:0]          filt_q, filt_d;
        logic                   rterm_q, rx_en_q, ready_q, idle_q, event_q, data_q;

        assign di_s = di_sync_q[SYNC_STAGES-1];
        assign ei_s = ei_sync_q[SYNC_STAGES-1];

        // Next-state, settle counter and EI filter; lane disable overrides everything.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            filt_d  = filt_q;
            if (!LANE_EN_I[g]) begin
                state_d = ST_OFF;
                cnt_d   = '0;
                filt_d  = '0;
            end else begin
                unique case (state_q)
                    ST_OFF: begin
                        state_d = ST_TERM;
                        cnt_d   = '0;
                        filt_d  = '0;
                    end
                    ST_TERM: begin
                        if (cnt_q == TERM_LAST) begin
                            state_d = ST_RXSET;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    ST_RXSET: begin
                        if (cnt_q == RX_LAST) begin
                            state_d = ST_ACTIVE;
                            cnt_d   = '0;
                            filt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (!ei_s) begin
                            filt_d = '0;
                        end else if (filt_q == FILT_LAST) begin
                            state_d = ST_IDLE;
                            filt_d  = '0;
                        end else begin
                            filt_d = filt_q + CNT_ONE;
                        end
                    end
                    ST_IDLE: begin
                        if (ei_s) begin
                            filt_d = '0;
                        end else if (filt_q == FILT_LAST) begin
                            state_d = ST_ACTIVE;
                            filt_d  = '0;
                        end else begin
                            filt_d = filt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_OFF;
                        cnt_d   = '0;
                        filt_d  = '0;
                    end
                endcase
            end
        end

        // Synchronisers, state registers and outputs decoded from the next state.
        always_ff @(posedge CLK_I or negedge RSTN_I) begin
            if (!RSTN_I) begin
                di_sync_q <= '0;
                ei_sync_q <= '0;
                state_q   <= ST_OFF;
                cnt_q     <= '0;
                filt_q    <= '0;
                rterm_q   <= 1'b0;
                rx_en_q   <= 1'b0;
                ready_q   <= 1'b0;
                idle_q    <= 1'b0;
                event_q   <= 1'b0;
                data_q    <= 1'b0;
            end else begin
                di_sync_q <= {di_sync_q[SYNC_STAGES-2:0], DI_I[g]};
                ei_sync_q <= {ei_sync_q[SYNC_STAGES-2:0], EI_DETECT_I[g]};
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                filt_q    <= filt_d;
                rterm_q   <= (state_d != ST_OFF);
                rx_en_q   <= (state_d == ST_RXSET) || (state_d == ST_ACTIVE) || (state_d == ST_IDLE);
                ready_q   <= (state_d == ST_ACTIVE);
                idle_q    <= (state_d == ST_IDLE);
                event_q   <= (state_q == ST_ACTIVE) && (state_d == ST_IDLE);
                data_q    <= (state_d == ST_ACTIVE) ? (di_s ^ RX_POL_I[g]) : 1'b0;
            end
        end

        assign RTERM_EN_O[g]     = rterm_q;
        assign RX_EN_O[g]        = rx_en_q;
        assign EI_DETECT_EN_O[g] = rx_en_q;
        assign LANE_READY_O[g]   = ready_q;
        assign LANE_IDLE_O[g]    = idle_q;
        assign EI_EVENT_O[g]     = event_q;
        assign DATA_O[g]         = data_q;
    end

endmodule
